i2s2_transceiver: RTL and testbench
===================================

// Module: i2s2_transceiver
// PURPOSE
//  I2S master for the Pmod I2S2 (CS5343 ADC / CS4344 DAC). Sits between the Pmod pins and the
//  Pmod_I2S2 AXI4-Lite register bank. Generates MCLK/SCLK/LRCK, deserialises stereo ADC samples
//  toward the register bank and serialises DAC samples from it, with valid/ready handshakes.
// PARAMETERS
//  MCLK_HALF  2  ACLK cycles per MCLK half-period, legal range >=2; fs = f_ACLK/(512*MCLK_HALF)
// PORTS
//  ACLK       in   1   system clock
//  ARESET     in   1   asynchronous active-high reset
//  tx_left    in   24  DAC left sample, signed
//  tx_right   in   24  DAC right sample, signed
//  tx_valid   in   1   tx sample pair available
//  tx_ready   out  1   one-cycle strobe at frame load; transfer when tx_valid&&tx_ready
//  rx_left    out  24  ADC left sample, signed
//  rx_right   out  24  ADC right sample, signed
//  rx_valid   out  1   rx pair held until accepted
//  rx_ready   in   1   consumer accepts the rx pair
//  rx_overrun out  1   one-cycle pulse when an unaccepted rx pair is overwritten
//  peak       out  24  max |sample| since clear (I2S2_PEAK_EN only, else tied 0)
//  peak_clr   in   1   synchronous peak clear (ignored without I2S2_PEAK_EN)
//  da_mclk/da_sclk/da_lrck  out 1  DAC clocks; da_sdin out 1  DAC serial data
//  ad_mclk/ad_sclk/ad_lrck  out 1  ADC clocks (same values as DA); ad_sdout in 1  ADC serial data
// BEHAVIOUR
//  - One ACLK domain; ARESET is async active-high. During reset all outputs are 0, ph=0 and shift regs are 0.
//  - Asserting ARESET mid-frame discards the partial frame. Release restarts at ph=0 with LRCK low.
//  - MCLK toggles every MCLK_HALF ACLK cycles. The 8-bit phase counter ph increments on each MCLK rise and wraps 255->0.
//  - SCLK=ph[1] (64 fs); LRCK=ph[7] (0=left). All clock outputs are registered.
//  - Slot bit b=ph[6:2]. b=0 is the I2S delay bit; b=1..24 carry MSB..LSB; b=25..31 are 0 on TX and ignored on RX.
//  - TX: da_sdin updates on the ACLK tick where ph[1:0] becomes 00 (SCLK falling).
//  - RX: ad_sdout passes through a 2-FF synchroniser. The synchronised value is sampled on the tick where ph[1:0] becomes 11.
//  - Frame boundary, i.e. ph 255->0:
//    - tx_ready pulses for 1 cycle. If tx_valid is high, tx_left/tx_right load into the shift regs.
//      Otherwise the previous pair is retransmitted; after reset the previous pair is 0.
//    - The completed rx pair is published to rx_left/rx_right and rx_valid is set.
//      If rx_valid was already 1 and is not accepted this cycle: overwrite and pulse rx_overrun.
//      If accepted in the same cycle: new data loads, rx_valid stays 1, no overrun.
//  - rx_valid clears on rx_valid&&rx_ready when no frame boundary occurs in that cycle.
//  - Output latency: a rx pair appears 1 ACLK cycle after the ph wrap that ends its right slot.
// CONFIGURATION
//  I2S2_PEAK_EN defined:
//   - At each rx publish, peak <= max(peak,|rx_left|,|rx_right|).
//   - |-2^23| saturates to 24'h7FFFFF.
//   - If peak_clr coincides with a publish, peak <= max(|l|,|r|) of that frame.
//   - Otherwise peak_clr sets peak to 0.
//  I2S2_PEAK_EN undefined: peak is constant 0, peak_clr is unused, and no peak logic is built.
// STRUCTURE
//  - Package i2s2_pkg: SAMPLE_W=24, SLOT_BITS=32, PH_W=8, typedef logic signed [23:0] sample_t, function abs_sat().
//  - Sub-module i2s2_clkgen: MCLK divider, ph counter, and one-cycle strobes (sclk_fall, sclk_mid, frame_start).
//  - The top level holds the shift registers, handshakes and peak logic.
// TESTING (MCLK_HALF=2: MCLK=4 ACLK cycles, SCLK=16, frame=1024)
//  1 Reset release -> da_mclk period 4, da_sclk period 16, da_lrck low for 512 cycles then high for 512; AD pins match DA pins.
//  2 tx 24'hA5A5A5/24'h123456 with valid -> tx_ready pulse accepts the pair.
//    da_sdin: left slot bit0=0, bits1..24=A5A5A5 MSB first, rest 0; right slot 123456 (bit0=0, rest 0) likewise.
//  3 ADC model drives 24'hC0FFEE/24'h800001 -> after the frame, rx_valid=1, rx_left=C0FFEE, rx_right=800001.
//  4 rx_ready=0 for 2 frames -> rx_overrun pulses once; rx holds frame-2 data.
//    rx_ready=1 on a boundary -> no overrun.
//  5 tx_valid=0 after test 2 -> A5A5A5/123456 is retransmitted each frame; tx_ready pulses once per 1024 cycles.
//  6 ARESET at ph=100 -> outputs 0 immediately; after release the first rx pair appears one full frame later.
//    With I2S2_PEAK_EN after test 3: peak=24'h7FFFFF; peak_clr -> 0.

Source files
------------

// File: rtl/i2s2_pkg.sv
// ============================================================================
// Module  : i2s2_pkg
// Brief   : Shared widths, sample type and magnitude helper for the I2S2 path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s2_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int SLOT_BITS = 32;
  localparam int PH_W      = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Magnitude of a signed sample; the most negative code clamps to full scale.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input sample_t s);
    if (s == sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}}))
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (s[SAMPLE_W-1])
      return -s;
    else
      return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s2_clkgen.sv
// ============================================================================
// Module  : i2s2_clkgen
// Brief   : MCLK divider, 8-bit frame phase counter and per-tick bit strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s2_clkgen
  import i2s2_pkg::*;
#(
  parameter int MCLK_HALF = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_mclk,
  output logic [PH_W-1:0] o_ph,
  output logic            o_sclk_fall,
  output logic            o_sclk_mid,
  output logic            o_frame_start
);

  localparam int c_div_w = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

  logic [c_div_w-1:0] r_div;
  logic               r_mclk;
  logic [PH_W-1:0]    r_ph;
  logic               w_div_end;
  logic               w_mclk_rise;

  assign w_div_end   = (r_div == c_div_w'(MCLK_HALF - 1));
  assign w_mclk_rise = w_div_end && !r_mclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_mclk <= 1'b0;
      r_ph   <= '0;
    end else begin
      r_div <= w_div_end ? '0 : r_div + 1'b1;
      if (w_div_end)
        r_mclk <= ~r_mclk;
      if (w_mclk_rise)
        r_ph <= r_ph + 1'b1;
    end
  end

  // Strobes fire on the tick where ph moves into the named state.
  assign o_sclk_fall   = w_mclk_rise && (r_ph[1:0] == 2'b11);
  assign o_sclk_mid    = w_mclk_rise && (r_ph[1:0] == 2'b10);
  assign o_frame_start = w_mclk_rise && (r_ph == '1);
  assign o_mclk        = r_mclk;
  assign o_ph          = r_ph;

endmodule

`default_nettype wire

// File: rtl/i2s2_transceiver.sv
// ============================================================================
// Module  : i2s2_transceiver
// Brief   : I2S master for Pmod I2S2; optional peak meter via I2S2_PEAK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s2_transceiver
  import i2s2_pkg::*;
#(
  parameter int MCLK_HALF = 2
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [SAMPLE_W-1:0] tx_left,
  input  logic [SAMPLE_W-1:0] tx_right,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [SAMPLE_W-1:0] rx_left,
  output logic [SAMPLE_W-1:0] rx_right,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_overrun,
  output logic [SAMPLE_W-1:0] peak,
  input  logic                peak_clr,
  output logic                da_mclk,
  output logic                da_sclk,
  output logic                da_lrck,
  output logic                da_sdin,
  output logic                ad_mclk,
  output logic                ad_sclk,
  output logic                ad_lrck,
  input  logic                ad_sdout
);

  localparam int c_bit_w = $clog2(SLOT_BITS);

  logic               w_mclk;
  logic [PH_W-1:0]    w_ph;
  logic [PH_W-1:0]    w_ph_nxt;
  logic               w_sclk_fall;
  logic               w_sclk_mid;
  logic               w_frame_start;
  logic [c_bit_w-1:0] w_bit;
  logic [c_bit_w-1:0] w_idx;
  logic               w_in_word;
  logic               w_unused_ph;
  sample_t            w_tx_word;

  i2s2_clkgen #(
    .MCLK_HALF(MCLK_HALF)
  ) u_clkgen (
    .clk          (ACLK),
    .rst          (ARESET),
    .o_mclk       (w_mclk),
    .o_ph         (w_ph),
    .o_sclk_fall  (w_sclk_fall),
    .o_sclk_mid   (w_sclk_mid),
    .o_frame_start(w_frame_start)
  );

  // Strobes refer to the phase being entered, so decode the slot bit from ph+1.
  assign w_ph_nxt    = w_ph + 1'b1;
  assign w_unused_ph = ^w_ph_nxt[1:0];
  assign w_bit       = w_ph_nxt[c_bit_w+1:2];
  assign w_in_word   = (w_bit != '0) && (w_bit <= c_bit_w'(SAMPLE_W));
  assign w_idx       = c_bit_w'(SAMPLE_W) - w_bit;

  sample_t r_tx_l, r_tx_r;
  logic    r_sdin;

  assign w_tx_word = w_ph_nxt[PH_W-1] ? r_tx_r : r_tx_l;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_tx_l <= '0;
      r_tx_r <= '0;
      r_sdin <= 1'b0;
    end else begin
      if (w_frame_start && tx_valid) begin
        r_tx_l <= tx_left;
        r_tx_r <= tx_right;
      end
      if (w_sclk_fall)
        r_sdin <= w_in_word ? w_tx_word[w_idx] : 1'b0;
    end
  end

  logic [1:0] r_sync;
  sample_t    r_sh_l, r_sh_r, r_rx_l, r_rx_r;
  logic       r_rx_valid;
  logic       r_overrun;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_sync     <= '0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
      r_rx_l     <= '0;
      r_rx_r     <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], ad_sdout};
      r_overrun <= 1'b0;
      if (w_sclk_mid && w_in_word) begin
        if (w_ph_nxt[PH_W-1])
          r_sh_r[w_idx] <= r_sync[1];
        else
          r_sh_l[w_idx] <= r_sync[1];
      end
      if (w_frame_start) begin
        r_rx_l     <= r_sh_l;
        r_rx_r     <= r_sh_r;
        r_rx_valid <= 1'b1;
        r_overrun  <= r_rx_valid && !rx_ready;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

`ifdef I2S2_PEAK_EN
  logic [SAMPLE_W-1:0] r_peak;
  logic [SAMPLE_W-1:0] w_abs_l, w_abs_r, w_frame_max;

  assign w_abs_l     = abs_sat(r_sh_l);
  assign w_abs_r     = abs_sat(r_sh_r);
  assign w_frame_max = (w_abs_l > w_abs_r) ? w_abs_l : w_abs_r;

  // A clear landing on a publish restarts the meter from that frame.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      r_peak <= '0;
    else if (w_frame_start)
      r_peak <= (peak_clr || (w_frame_max > r_peak)) ? w_frame_max : r_peak;
    else if (peak_clr)
      r_peak <= '0;
  end

  assign peak = r_peak;
`else
  logic w_unused_clr;
  assign w_unused_clr = peak_clr;
  assign peak         = '0;
`endif

  assign tx_ready   = w_frame_start;
  assign rx_left    = r_rx_l;
  assign rx_right   = r_rx_r;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_overrun;
  assign da_mclk    = w_mclk;
  assign da_sclk    = w_ph[1];
  assign da_lrck    = w_ph[PH_W-1];
  assign da_sdin    = r_sdin;
  assign ad_mclk    = w_mclk;
  assign ad_sclk    = w_ph[1];
  assign ad_lrck    = w_ph[PH_W-1];

endmodule

`default_nettype wire

// File: tb/tb_i2s2_transceiver.sv
// ============================================================================
// Module  : tb_i2s2_transceiver
// Brief   : Pin-level ADC/DAC models and handshake scoreboard for i2s2_transceiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s2_transceiver;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [23:0] tx_left = '0, tx_right = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [23:0] rx_left, rx_right, peak;
  logic        rx_valid, rx_overrun;
  logic        rx_ready = 1'b1;
  logic        peak_clr = 1'b0;
  logic        da_mclk, da_sclk, da_lrck, da_sdin;
  logic        ad_mclk, ad_sclk, ad_lrck;
  logic        ad_sdout = 1'b0;

  always #5 ACLK = ~ACLK;

  i2s2_transceiver #(.MCLK_HALF(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .peak(peak), .peak_clr(peak_clr),
    .da_mclk(da_mclk), .da_sclk(da_sclk), .da_lrck(da_lrck), .da_sdin(da_sdin),
    .ad_mclk(ad_mclk), .ad_sclk(ad_sclk), .ad_lrck(ad_lrck), .ad_sdout(ad_sdout)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [23:0] mag(input logic signed [23:0] s);
    int v;
    v = s;
    if (v < 0) v = -v;
    if (v > 8388607) v = 8388607;
    return v[23:0];
  endfunction

  // Reference state: pin history, ADC source pair, expected DAC pair, rx/peak scoreboard
  logic        p_sclk, p_mclk, p_lrck, fr_lrck, was_rst, first_pair_done = 1'b0;
  int          pos, last_mclk, last_sclk, last_lrck, last_txr = -1, n_lrck;
  logic [23:0] adc_l, adc_r, exp_tx_l, exp_tx_r, dac_acc, fm;
  logic        dac_pad_bad, m_valid, m_ovr;
  logic [23:0] m_rx_l, m_rx_r, m_peak;

  task automatic new_adc_pair();
    if (!first_pair_done) begin
      adc_l = 24'hC0FFEE;
      adc_r = 24'h800001;
      first_pair_done = 1'b1;
    end else begin
      adc_l = 24'($urandom);
      adc_r = 24'($urandom);
      case ($urandom_range(0, 5))
        0: adc_l = 24'h800000;
        1: adc_r = 24'h7FFFFF;
        default: ;
      endcase
    end
  endtask

  always @(negedge ACLK) begin
    cyc++;
    if (ARESET) begin
      if (!was_rst) new_adc_pair();
      was_rst = 1'b1;
      p_sclk = 0; p_mclk = 0; p_lrck = 0; fr_lrck = 0; pos = 0;
      last_mclk = -1; last_sclk = -1; last_lrck = -1; last_txr = -1; n_lrck = 0;
      exp_tx_l = '0; exp_tx_r = '0; dac_acc = '0; dac_pad_bad = 0;
      m_valid = 0; m_ovr = 0; m_rx_l = '0; m_rx_r = '0; m_peak = '0;
      ad_sdout = 1'b0;
    end else begin
      was_rst = 1'b0;
      check_eq("ad_pins", {ad_mclk, ad_sclk, ad_lrck}, {da_mclk, da_sclk, da_lrck});
      if (da_mclk && !p_mclk) begin
        if (last_mclk >= 0) check_eq("mclk_period", cyc - last_mclk, 4);
        last_mclk = cyc;
      end
      if (da_sclk && !p_sclk) begin
        if (last_sclk >= 0) check_eq("sclk_period", cyc - last_sclk, 16);
        last_sclk = cyc;
      end
      if (da_lrck != p_lrck) begin
        n_lrck++;
        if (n_lrck >= 2) check_eq("lrck_half", cyc - last_lrck, 512);
        last_lrck = cyc;
      end
      // ADC side: I2S transmitter driving one bit per SCLK falling edge
      if (!da_sclk && p_sclk) begin
        if (da_lrck != fr_lrck) begin
          pos = 0;
          if (!da_lrck) new_adc_pair();
        end else begin
          pos++;
        end
        fr_lrck = da_lrck;
        if (pos >= 1 && pos <= 24) ad_sdout = da_lrck ? adc_r[24-pos] : adc_l[24-pos];
        else ad_sdout = 1'($urandom_range(0, 1));
      end
      // DAC side: I2S receiver sampling on SCLK rising edges
      if (da_sclk && !p_sclk) begin
        if (pos >= 1 && pos <= 24) dac_acc = {dac_acc[22:0], da_sdin};
        else if (da_sdin) dac_pad_bad = 1'b1;
        if (pos == 24)
          check_eq(da_lrck ? "dac_right" : "dac_left", dac_acc, da_lrck ? exp_tx_r : exp_tx_l);
        if (pos == 31) begin
          check_eq("dac_pad_zero", dac_pad_bad, 0);
          dac_pad_bad = 1'b0;
        end
      end
      if (tx_ready) begin
        if (last_txr >= 0) check_eq("tx_ready_period", cyc - last_txr, 1024);
        last_txr = cyc;
        if (tx_valid) begin
          exp_tx_l = tx_left;
          exp_tx_r = tx_right;
        end
      end
      check_eq("rx_valid", rx_valid, m_valid);
      check_eq("rx_overrun", rx_overrun, m_ovr);
      check_eq("rx_pair", {rx_left, rx_right}, {m_rx_l, m_rx_r});
      check_eq("peak", peak, m_peak);
      if (tx_ready) begin
        m_ovr   = m_valid && !rx_ready;
        m_valid = 1'b1;
        m_rx_l  = adc_l;
        m_rx_r  = adc_r;
`ifdef I2S2_PEAK_EN
        fm = (mag(adc_l) > mag(adc_r)) ? mag(adc_l) : mag(adc_r);
        if (peak_clr || fm > m_peak) m_peak = fm;
`endif
      end else begin
        m_ovr = 1'b0;
        if (m_valid && rx_ready) m_valid = 1'b0;
`ifdef I2S2_PEAK_EN
        if (peak_clr) m_peak = '0;
`endif
      end
      p_sclk = da_sclk; p_mclk = da_mclk; p_lrck = da_lrck;
    end
  end

  task automatic wait_txready();
    for (int i = 0; i < 1100; i++) begin
      @(posedge ACLK); #1;
      if (tx_ready) return;
    end
    check_eq("tx_ready_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_clocks"}, {da_mclk, da_sclk, da_lrck, ad_mclk, ad_sclk, ad_lrck, da_sdin}, 0);
    check_eq({tag, "_hs"}, {tx_ready, rx_valid, rx_overrun}, 0);
    check_eq({tag, "_rx"}, {rx_left, rx_right}, 0);
    check_eq({tag, "_peak"}, peak, 0);
  endtask

  initial begin
    int lat;
    #1 ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #2 check_reset_outputs("reset");
    @(posedge ACLK); #1 ARESET = 1'b0;

    // Frame 0: nothing offered, DAC must send zeros; ADC sends C0FFEE/800001
    wait_txready();
    @(posedge ACLK); #1;
    check_eq("first_rx", {rx_valid, rx_left, rx_right}, {1'b1, 24'hC0FFEE, 24'h800001});
`ifdef I2S2_PEAK_EN
    check_eq("first_peak", peak, 24'h7FFFFF);
`endif

    tx_left = 24'hA5A5A5; tx_right = 24'h123456; tx_valid = 1'b1;
    wait_txready();
    @(posedge ACLK); #1 tx_valid = 1'b0;
    repeat (2) wait_txready();

    rx_ready = 1'b0;
    repeat (3) wait_txready();
    rx_ready = 1'b1;

    peak_clr = 1'b1;
    @(posedge ACLK); #1 peak_clr = 1'b0;
    repeat (200) @(posedge ACLK);
    #1 peak_clr = 1'b1;
    @(posedge ACLK); #1 peak_clr = 1'b0;
    wait_txready();
    peak_clr = 1'b1;
    @(posedge ACLK); #1 peak_clr = 1'b0;

    for (int f = 0; f < 5; f++) begin
      tx_left  = 24'($urandom);
      tx_right = 24'($urandom);
      tx_valid = 1'($urandom_range(0, 1));
      for (int c = 0; c < 1024; c++) begin
        @(posedge ACLK); #1;
        rx_ready = ($urandom_range(0, 3) == 0);
        peak_clr = ($urandom_range(0, 700) == 0);
      end
    end
    rx_ready = 1'b1; peak_clr = 1'b0; tx_valid = 1'b0;

    // Asynchronous reset around ph=100 of a frame
    lat = 0;
    while (!(last_txr >= 0 && cyc - last_txr >= 400) && lat < 2200) begin
      @(posedge ACLK); #1 lat++;
    end
    check_eq("mid_frame_reached", lat < 2200, 1);
    #1 ARESET = 1'b1;
    #1 check_reset_outputs("areset");
    repeat (4) @(posedge ACLK);
    #1 ARESET = 1'b0;
    lat = 0;
    while (!rx_valid && lat < 1200) begin
      @(posedge ACLK); #1 lat++;
    end
    check_eq("rx_after_reset_window", (lat >= 1018 && lat <= 1026), 1);

    tx_left = 24'h7FFFFF; tx_right = 24'h800000; tx_valid = 1'b1;
    repeat (2) wait_txready();
    repeat (20) @(posedge ACLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
